// File: rtl/pipelined_adder_sub.sv
// Pipelined WIDTH-bit adder/subtractor. Resolves CHUNK bits of the carry chain per stage
// and uses valid/ready handshakes on both sides.
module pipelined_adder_sub #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   input  logic             Mode,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] S,
   output logic             Cout,
   output logic             Ovf,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int STAGES = WIDTH / CHUNK;
   localparam int LAST   = STAGES - 1;

   if ((WIDTH % CHUNK) != 0) begin : g_cfg_check
      $error("pipelined_adder_sub: WIDTH must be a multiple of CHUNK");
   end

   logic [STAGES-1:0] r_v;
   logic [STAGES-1:0] r_c;
   logic [WIDTH-1:0]  r_a    [STAGES];
   logic [WIDTH-1:0]  r_b    [STAGES];
   logic [WIDTH-1:0]  r_s    [STAGES];
   logic              r_mode [STAGES];
   logic              r_sa   [STAGES];
   logic              r_sb   [STAGES];
   logic              r_ovf;

   logic [STAGES-1:0] w_load;
   logic [STAGES-1:0] w_src_v;
   logic [STAGES-1:0] w_src_c;
   logic [WIDTH-1:0]  w_src_a    [STAGES];
   logic [WIDTH-1:0]  w_src_b    [STAGES];
   logic [WIDTH-1:0]  w_src_s    [STAGES];
   logic [WIDTH-1:0]  w_s_new    [STAGES];
   logic              w_src_mode [STAGES];
   logic              w_src_sa   [STAGES];
   logic              w_src_sb   [STAGES];
   logic [CHUNK:0]    w_chunk    [STAGES];
   logic              w_ready_chain;
   logic              w_ovf_new;

   // A stage may load when it is empty or its contents move on this cycle;
   // walking from the output backwards lets bubbles collapse under backpressure.
   always_comb begin
      w_load        = '0;
      w_ready_chain = out_ready;
      for (int k = LAST; k >= 0; k--) begin
         w_load[k]     = !r_v[k] || w_ready_chain;
         w_ready_chain = w_load[k];
      end
   end

   assign in_ready = w_load[0];

   // Subtraction is A + ~B + ~Cin, so B and the carry-in are conditioned once at entry.
   always_comb begin
      w_src_v       = '0;
      w_src_c       = '0;
      w_src_v[0]    = in_valid;
      w_src_a[0]    = A;
      w_src_b[0]    = Mode ? ~B : B;
      w_src_s[0]    = '0;
      w_src_c[0]    = Mode ? ~Cin : Cin;
      w_src_mode[0] = Mode;
      w_src_sa[0]   = A[WIDTH-1];
      w_src_sb[0]   = B[WIDTH-1];
      for (int k = 1; k < STAGES; k++) begin
         w_src_v[k]    = r_v[k-1];
         w_src_a[k]    = r_a[k-1];
         w_src_b[k]    = r_b[k-1];
         w_src_s[k]    = r_s[k-1];
         w_src_c[k]    = r_c[k-1];
         w_src_mode[k] = r_mode[k-1];
         w_src_sa[k]   = r_sa[k-1];
         w_src_sb[k]   = r_sb[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
         w_chunk[k] = {1'b0, w_src_a[k][k*CHUNK +: CHUNK]}
                    + {1'b0, w_src_b[k][k*CHUNK +: CHUNK]}
                    + {{CHUNK{1'b0}}, w_src_c[k]};
         w_s_new[k] = w_src_s[k];
         w_s_new[k][k*CHUNK +: CHUNK] = w_chunk[k][CHUNK-1:0];
      end
      if (w_src_mode[LAST])
         w_ovf_new = (w_src_sa[LAST] != w_src_sb[LAST]) &&
                     (w_s_new[LAST][WIDTH-1] != w_src_sa[LAST]);
      else
         w_ovf_new = (w_src_sa[LAST] == w_src_sb[LAST]) &&
                     (w_s_new[LAST][WIDTH-1] != w_src_sa[LAST]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v   <= '0;
         r_c   <= '0;
         r_ovf <= 1'b0;
         for (int k = 0; k < STAGES; k++) begin
            r_a[k]    <= '0;
            r_b[k]    <= '0;
            r_s[k]    <= '0;
            r_mode[k] <= 1'b0;
            r_sa[k]   <= 1'b0;
            r_sb[k]   <= 1'b0;
         end
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (w_load[k]) begin
               r_v[k] <= w_src_v[k];
               if (w_src_v[k]) begin
                  r_a[k]    <= w_src_a[k];
                  r_b[k]    <= w_src_b[k];
                  r_s[k]    <= w_s_new[k];
                  r_c[k]    <= w_chunk[k][CHUNK];
                  r_mode[k] <= w_src_mode[k];
                  r_sa[k]   <= w_src_sa[k];
                  r_sb[k]   <= w_src_sb[k];
               end
            end
         end
         if (w_load[LAST] && w_src_v[LAST])
            r_ovf <= w_ovf_new;
      end
   end

   assign S         = r_s[LAST];
   assign Cout      = r_c[LAST];
   assign Ovf       = r_ovf;
   assign out_valid = r_v[LAST];

endmodule

// File: tb/tb_pipelined_adder_sub.sv
// Directed self-checking bench for pipelined_adder_sub (default 16/4 and a single-stage 4/4 build).
module tb_pipelined_adder_sub;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] A, B, S;
   logic        Cin, Mode, in_valid, in_ready, Cout, Ovf, out_valid, out_ready;
   logic [3:0]  a4, b4, s4;
   logic        cin4, mode4, iv4, ir4, co4, ov4, ovl4, ordy4;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   pipelined_adder_sub #(.WIDTH(16), .CHUNK(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .A(A), .B(B), .Cin(Cin), .Mode(Mode),
      .in_valid(in_valid), .in_ready(in_ready), .S(S), .Cout(Cout), .Ovf(Ovf),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   pipelined_adder_sub #(.WIDTH(4), .CHUNK(4)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .A(a4), .B(b4), .Cin(cin4), .Mode(mode4),
      .in_valid(iv4), .in_ready(ir4), .S(s4), .Cout(co4), .Ovf(ov4),
      .out_valid(ovl4), .out_ready(ordy4)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents one operand set, then waits (bounded) for its result and consumes it.
   task automatic run_one(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input logic mode, output int lat, output logic [15:0] s,
                          output logic co, output logic ov);
      A = a; B = b; Cin = cin; Mode = mode; in_valid = 1'b1; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      lat = 1;
      while (out_valid !== 1'b1 && lat < 12) begin
         step();
         lat++;
      end
      s = S; co = Cout; ov = Ovf;
      step();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step();
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++; if (S !== 16'h0000) begin errors++; $display("FAIL reset_s: got %h expected 0000", S); end
      checks++; if (Cout !== 1'b0 || Ovf !== 1'b0) begin errors++; $display("FAIL reset_flags: got cout=%b ovf=%b expected 0 0", Cout, Ovf); end
      rst_n = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
   endtask

   task automatic test_add();
      int lat; logic [15:0] s; logic co, ov;
      run_one(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat, s, co, ov);
      checks++; if (lat !== 4) begin errors++; $display("FAIL add_latency: got %0d expected 4", lat); end
      checks++; if (s !== 16'h0000) begin errors++; $display("FAIL add_sum: got %h expected 0000", s); end
      checks++; if (co !== 1'b1 || ov !== 1'b0) begin errors++; $display("FAIL add_flags: got cout=%b ovf=%b expected 1 0", co, ov); end
   endtask

   task automatic test_sub();
      int lat; logic [15:0] s; logic co, ov;
      run_one(16'h0005, 16'h0007, 1'b0, 1'b1, lat, s, co, ov);
      checks++; if (s !== 16'hFFFE) begin errors++; $display("FAIL sub1_diff: got %h expected fffe", s); end
      checks++; if (co !== 1'b0 || ov !== 1'b0) begin errors++; $display("FAIL sub1_flags: got cout=%b ovf=%b expected 0 0", co, ov); end
      run_one(16'h0007, 16'h0005, 1'b1, 1'b1, lat, s, co, ov);
      checks++; if (s !== 16'h0001) begin errors++; $display("FAIL sub2_diff: got %h expected 0001", s); end
      checks++; if (co !== 1'b1 || ov !== 1'b0) begin errors++; $display("FAIL sub2_flags: got cout=%b ovf=%b expected 1 0", co, ov); end
   endtask

   task automatic test_overflow();
      int lat; logic [15:0] s; logic co, ov;
      run_one(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat, s, co, ov);
      checks++; if (s !== 16'h8000) begin errors++; $display("FAIL ovf_add_sum: got %h expected 8000", s); end
      checks++; if (ov !== 1'b1 || co !== 1'b0) begin errors++; $display("FAIL ovf_add_flags: got ovf=%b cout=%b expected 1 0", ov, co); end
      run_one(16'h8000, 16'h0001, 1'b0, 1'b1, lat, s, co, ov);
      checks++; if (s !== 16'h7FFF) begin errors++; $display("FAIL ovf_sub_diff: got %h expected 7fff", s); end
      checks++; if (ov !== 1'b1 || co !== 1'b1) begin errors++; $display("FAIL ovf_sub_flags: got ovf=%b cout=%b expected 1 1", ov, co); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] exp_s [8];
      int   nout;
      logic ok_valid, ok_ready;
      exp_s = '{16'd1, 16'd4, 16'd5, 16'd8, 16'd9, 16'd12, 16'd13, 16'd16};
      nout = 0; ok_valid = 1'b1; ok_ready = 1'b1;
      out_ready = 1'b1; Mode = 1'b0;
      for (int cyc = 0; cyc < 16; cyc++) begin
         if (out_valid === 1'b1) begin
            checks++;
            if (nout > 7) begin
               errors++; $display("FAIL stream_extra: got result %h expected none", S);
            end else if (S !== exp_s[nout]) begin
               errors++; $display("FAIL stream_sum[%0d]: got %h expected %h", nout, S, exp_s[nout]);
            end
            nout++;
         end
         if (cyc >= 4 && cyc <= 11 && out_valid !== 1'b1) ok_valid = 1'b0;
         if (cyc < 8) begin
            A = 16'(cyc); B = 16'(cyc + 1); Cin = cyc[0]; in_valid = 1'b1;
            if (in_ready !== 1'b1) ok_ready = 1'b0;
         end else begin
            in_valid = 1'b0;
         end
         step();
      end
      checks++; if (nout !== 8) begin errors++; $display("FAIL stream_count: got %0d expected 8", nout); end
      checks++; if (ok_valid !== 1'b1) begin errors++; $display("FAIL stream_consecutive: got gap expected 8 consecutive"); end
      checks++; if (ok_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready: got drop expected constant 1"); end
   endtask

   task automatic test_backpressure();
      logic [15:0] exp_s [6];
      int   idx, n;
      logic acc, ok_hold;
      exp_s = '{16'h0100, 16'h0111, 16'h0122, 16'h0133, 16'h0144, 16'h0155};
      idx = 0; ok_hold = 1'b1;
      out_ready = 1'b0; Mode = 1'b0; Cin = 1'b0;
      for (int cyc = 0; cyc < 6; cyc++) begin
         A = 16'h0100 + 16'(idx); B = 16'(idx * 16); in_valid = 1'b1;
         if (cyc >= 4 && (out_valid !== 1'b1 || S !== exp_s[0])) ok_hold = 1'b0;
         acc = in_ready;
         step();
         if (acc) idx++;
      end
      checks++; if (idx !== 4) begin errors++; $display("FAIL bp_accepted: got %0d expected 4", idx); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
      checks++; if (ok_hold !== 1'b1 || out_valid !== 1'b1 || S !== exp_s[0]) begin
         errors++; $display("FAIL bp_hold: got valid=%b s=%h expected 1 %h", out_valid, S, exp_s[0]);
      end
      in_valid = 1'b0; out_ready = 1'b1; n = 0;
      for (int cyc = 0; cyc < 12; cyc++) begin
         if (out_valid === 1'b1) begin
            checks++;
            if (n > 3) begin
               errors++; $display("FAIL bp_extra: got result %h expected none", S);
            end else if (S !== exp_s[n]) begin
               errors++; $display("FAIL bp_drain[%0d]: got %h expected %h", n, S, exp_s[n]);
            end
            n++;
         end
         step();
      end
      checks++; if (n !== 4) begin errors++; $display("FAIL bp_drain_count: got %0d expected 4", n); end
   endtask

   task automatic test_reset_midflight();
      int lat; logic [15:0] s; logic co, ov;
      logic stale;
      out_ready = 1'b1; Mode = 1'b0; Cin = 1'b0;
      for (int i = 0; i < 3; i++) begin
         A = 16'h1000 * 16'(i + 1); B = 16'h0001; in_valid = 1'b1;
         step();
      end
      in_valid = 1'b0; out_ready = 1'b0;
      step();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre_valid: got %b expected 1", out_valid); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0 || S !== 16'h0000) begin
         errors++; $display("FAIL midrst_async: got valid=%b s=%h expected 0 0000", out_valid, S);
      end
      step();
      step();
      rst_n = 1'b1;
      out_ready = 1'b1;
      stale = 1'b0;
      for (int cyc = 0; cyc < 8; cyc++) begin
         if (out_valid !== 1'b0) stale = 1'b1;
         step();
      end
      checks++; if (stale !== 1'b0) begin errors++; $display("FAIL midrst_stale: got stale output expected none"); end
      run_one(16'h1234, 16'h1111, 1'b0, 1'b0, lat, s, co, ov);
      checks++; if (lat !== 4) begin errors++; $display("FAIL midrst_latency: got %0d expected 4", lat); end
      checks++; if (s !== 16'h2345) begin errors++; $display("FAIL midrst_sum: got %h expected 2345", s); end
   endtask

   task automatic test_single_stage();
      a4 = 4'hF; b4 = 4'h1; cin4 = 1'b0; mode4 = 1'b0; iv4 = 1'b1; ordy4 = 1'b1;
      checks++; if (ir4 !== 1'b1 || ovl4 !== 1'b0) begin errors++; $display("FAIL single_pre: got ready=%b valid=%b expected 1 0", ir4, ovl4); end
      step();
      iv4 = 1'b0;
      checks++; if (ovl4 !== 1'b1) begin errors++; $display("FAIL single_latency: got valid=%b expected 1", ovl4); end
      checks++; if (s4 !== 4'h0 || co4 !== 1'b1 || ov4 !== 1'b0) begin
         errors++; $display("FAIL single_result: got s=%h cout=%b ovf=%b expected 0 1 0", s4, co4, ov4);
      end
      step();
   endtask

   initial begin
      A = '0; B = '0; Cin = 1'b0; Mode = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      a4 = '0; b4 = '0; cin4 = 1'b0; mode4 = 1'b0; iv4 = 1'b0; ordy4 = 1'b1;
      test_reset();
      test_add();
      test_sub();
      test_overflow();
      test_back_to_back();
      test_backpressure();
      test_reset_midflight();
      test_single_stage();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipelined_adder_sub.md
Name: pipelined_adder_sub

Overview:
- Parametrised, pipelined binary adder/subtractor for the datapath library.
- Generalises the fixed 4-bit ripple adder to WIDTH bits.
- The carry chain is split into CHUNK-bit slices, one slice per pipeline stage, so timing is independent of WIDTH.
- Valid/ready handshakes on input and output let it sit between streaming blocks with backpressure.

Parameters:
- WIDTH, 16, operand and sum width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits resolved per pipeline stage; STAGES = WIDTH/CHUNK.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- Cin  input  1  carry-in (add) / borrow-in (sub)
- Mode  input  1  0 = add, 1 = subtract
- in_valid  input  1  A/B/Cin/Mode valid this cycle
- in_ready  output  1  block accepts input this cycle
- S  output  WIDTH  result
- Cout  output  1  carry-out (add) / not-borrow (sub)
- Ovf  output  1  two's-complement signed overflow
- out_valid  output  1  S/Cout/Ovf valid
- out_ready  input  1  downstream accepts result

Behaviour:
- Clock and reset: single clock, clk. Reset is asynchronous, active-low on rst_n.
- Reset values: all stage valid bits = 0, out_valid = 0, S = 0, Cout = 0, Ovf = 0. in_ready = 1 after reset.
- Arithmetic, Mode = 0: {Cout,S} = A + B + Cin.
- Arithmetic, Mode = 1: computed as A + ~B + ~Cin.
  - S = A - B - Cin, modulo 2^WIDTH.
  - Cout = 1 when no borrow occurs (A >= B + Cin, unsigned).
- Ovf:
  - Mode 0: 1 when A[MSB] == B[MSB] and S[MSB] != A[MSB].
  - Mode 1: 1 when A[MSB] != B[MSB] and S[MSB] != A[MSB].
- Transfers: an input transfer happens when in_valid && in_ready. An output transfer happens when out_valid && out_ready.
- Pipeline: STAGES register stages, each with its own valid bit.
  - Stage k adds bits [k*CHUNK +: CHUNK] using the carry registered by stage k-1. Stage 0 uses Cin or ~Cin according to Mode.
  - Each stage carries the unprocessed upper operand bits, the already-resolved lower sum bits, the carry, Mode, and the operand sign bits needed for Ovf.
  - Last stage output is registered: S, Cout, Ovf and out_valid come directly from flops.
- Latency: STAGES cycles from input transfer to out_valid, with out_ready held high (4 cycles at the defaults).
- Throughput: one result per cycle when not stalled.
- Stage advance rule: stage k loads from stage k-1 when stage k is empty, or when stage k is itself advancing. Bubbles collapse under backpressure.
- in_ready = !stage0_valid || stage0_advancing. This is combinational from out_ready through the stage valid chain. No combinational path from in_valid to in_ready.
- Stall: while out_valid && !out_ready, S/Cout/Ovf hold stable. No result is lost or duplicated. The pipe fills, then in_ready drops.
- Simultaneous output and input transfer in the same cycle when the pipe is full: both complete, and occupancy is unchanged.
- Ordering: results emerge in input order.
- Reset mid-operation: all in-flight results are discarded. out_valid = 0 on the next clock-free evaluation (asynchronous). No stale result appears after rst_n rises.
- Edge cases:
  - WIDTH == CHUNK is legal: a single stage, latency 1.
  - A WIDTH that is not a multiple of CHUNK is a configuration error, flagged by an elaboration-time check.

Test Plan:
- Defaults, Mode = 0: A = 16'hFFFF, B = 16'h0001, Cin = 0 -> S = 16'h0000, Cout = 1, Ovf = 0; out_valid exactly 4 cycles after the transfer.
- Mode = 1: A = 16'h0005, B = 16'h0007, Cin = 0 -> S = 16'hFFFE, Cout = 0, Ovf = 0. Then A = 16'h0007, B = 16'h0005, Cin = 1 -> S = 16'h0001, Cout = 1.
- Overflow:
  - Mode 0: A = 16'h7FFF, B = 16'h0001 -> S = 16'h8000, Ovf = 1.
  - Mode 1: A = 16'h8000, B = 16'h0001 -> S = 16'h7FFF, Ovf = 1, Cout = 1.
- Streaming: 8 back-to-back inputs (i, i+1, Cin = i[0]) with out_ready = 1 -> 8 consecutive out_valid cycles, in order, correct sums, in_ready constantly 1.
- Backpressure:
  - out_ready = 0 for 6 cycles while feeding 6 inputs -> in_ready drops after 4 accepted (pipe full); the first result is held stable.
  - Release out_ready -> all accepted results drain in order, none dropped or duplicated.
- Reset mid-flight: assert rst_n = 0 with 3 results in flight -> out_valid = 0 immediately. After release, no output appears until a new input is accepted; that input's result arrives after 4 cycles.
